// File: rtl/bus_cycle_scheduler_pkg.sv
// Shared bus-FSM state encodings, transfer size codes and request decode helpers
// for the bus-cycle scheduler.
package bus_cycle_scheduler_pkg;

  localparam logic [3:0] STATE_IDLE          = 4'd0;
  localparam logic [3:0] STATE_WAIT          = 4'd1;
  localparam logic [3:0] STATE_SETUP_BUS     = 4'd2;
  localparam logic [3:0] STATE_ASSERT_STROBE = 4'd3;
  localparam logic [3:0] STATE_WAIT_DSACK    = 4'd4;
  localparam logic [3:0] STATE_LATCH         = 4'd5;
  localparam logic [3:0] STATE_FINALIZE      = 4'd6;
  localparam logic [3:0] STATE_CONTINUE      = 4'd7;

  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_LONG = 2'd3;

  // Illegal size, or a word/long that is not on an even address.
  function automatic logic decode_err(input logic [1:0] size, input logic a0);
    return (size == 2'd0) || ((size == SIZE_WORD || size == SIZE_LONG) && a0);
  endfunction

  function automatic logic [1:0] first_half_size(input logic [1:0] size);
    return (size == SIZE_LONG) ? SIZE_WORD : size;
  endfunction

  function automatic logic [15:0] first_half_dout(input logic [1:0] size,
                                                  input logic [31:0] wdata);
    case (size)
      SIZE_LONG: return wdata[31:16];
      SIZE_BYTE: return {wdata[7:0], wdata[7:0]};
      default:   return wdata[15:0];
    endcase
  endfunction

endpackage

// File: rtl/bus_cycle_scheduler_rr_arbiter2.sv
// Two-way round-robin grant; the pointer toggles on every grant taken.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;

  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | ~ptr_q);
    gnt_o[1] = req_i[1] & (~req_i[0] |  ptr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      ptr_q <= 1'b0;
    else if (|req_i)  ptr_q <= ~ptr_q;
  end

endmodule

// File: rtl/bus_cycle_scheduler.sv
// Shares the 68k bus-cycle FSM between two requesters, splitting long transfers
// into two word cycles and returning data/completion to the granted port.
module bus_cycle_scheduler
  import bus_cycle_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              REQ0_VALID,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [1:0]        REQ0_SIZE,
  input  logic              REQ0_RW,
  input  logic [31:0]       REQ0_WDATA,
  output logic              REQ0_ACK,
  input  logic              REQ1_VALID,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [1:0]        REQ1_SIZE,
  input  logic              REQ1_RW,
  input  logic [31:0]       REQ1_WDATA,
  output logic              REQ1_ACK,
  output logic              RESP0_VALID,
  output logic              RESP1_VALID,
  output logic [31:0]       RESP_RDATA,
  output logic              RESP_ERR,
  input  logic [3:0]        FSM_STATE,
  input  logic [15:0]       BUS_DIN,
  output logic              ACTIVATE,
  output logic              MUST_CONTINUE,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [1:0]        BUS_SIZE,
  output logic              BUS_RW,
  output logic [15:0]       BUS_DOUT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        ack_q, ack_d;
  logic              port_q, port_d;
  logic [1:0]        size_q, size_d;
  logic              rw_q, rw_d;
  logic              a0_q, a0_d;
  logic [15:0]       wlo_q, wlo_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [1:0]        bus_size_q, bus_size_d;
  logic [15:0]       bus_dout_q, bus_dout_d;
  logic              must_cont_q, must_cont_d;
  logic              second_q, second_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              activate;

  logic [1:0]        gnt;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_rw;
  logic [31:0]       req_wdata;
  logic              req_err;

  rr_arbiter2 u_arb (
    .clk_i  (CLK),
    .rst_ni (nRESET),
    .req_i  ({REQ1_VALID, REQ0_VALID} & {2{state_q == S_IDLE}}),
    .gnt_o  (gnt)
  );

  always_comb begin
    req_addr  = gnt[1] ? REQ1_ADDR  : REQ0_ADDR;
    req_size  = gnt[1] ? REQ1_SIZE  : REQ0_SIZE;
    req_rw    = gnt[1] ? REQ1_RW    : REQ0_RW;
    req_wdata = gnt[1] ? REQ1_WDATA : REQ0_WDATA;
    req_err   = decode_err(req_size, req_addr[0]);
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    port_d      = port_q;
    size_d      = size_q;
    rw_d        = rw_q;
    a0_d        = a0_q;
    wlo_d       = wlo_q;
    bus_addr_d  = bus_addr_q;
    bus_size_d  = bus_size_q;
    bus_dout_d  = bus_dout_q;
    must_cont_d = must_cont_q;
    second_d    = second_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    activate    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          ack_d       = gnt;
          port_d      = gnt[1];
          size_d      = req_size;
          rw_d        = req_rw;
          a0_d        = req_addr[0];
          wlo_d       = req_wdata[15:0];
          bus_addr_d  = req_addr;
          bus_size_d  = first_half_size(req_size);
          bus_dout_d  = first_half_dout(req_size, req_wdata);
          must_cont_d = (req_size == SIZE_LONG) && !req_err;
          second_d    = 1'b0;
          rdata_d     = '0;
          err_d       = req_err;
          state_d     = req_err ? S_RESPOND : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (FSM_STATE == STATE_WAIT) begin
          activate = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        case (FSM_STATE)
          STATE_LATCH: begin
            if (size_q == SIZE_BYTE)
              rdata_d[7:0] = a0_q ? BUS_DIN[7:0] : BUS_DIN[15:8];
            else if (size_q == SIZE_LONG && !second_q)
              rdata_d[31:16] = BUS_DIN;
            else
              rdata_d[15:0] = BUS_DIN;
          end
          // Second-half setup is registered here so it is stable by SETUP_BUS.
          STATE_CONTINUE: begin
            bus_addr_d  = bus_addr_q + ADDR_W'(2);
            bus_dout_d  = wlo_q;
            must_cont_d = 1'b0;
            second_d    = 1'b1;
          end
          STATE_FINALIZE: begin
            if (!must_cont_q) state_d = S_RESPOND;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      ack_q       <= '0;
      port_q      <= 1'b0;
      size_q      <= '0;
      rw_q        <= 1'b0;
      a0_q        <= 1'b0;
      wlo_q       <= '0;
      bus_addr_q  <= '0;
      bus_size_q  <= '0;
      bus_dout_q  <= '0;
      must_cont_q <= 1'b0;
      second_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      port_q      <= port_d;
      size_q      <= size_d;
      rw_q        <= rw_d;
      a0_q        <= a0_d;
      wlo_q       <= wlo_d;
      bus_addr_q  <= bus_addr_d;
      bus_size_q  <= bus_size_d;
      bus_dout_q  <= bus_dout_d;
      must_cont_q <= must_cont_d;
      second_q    <= second_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign REQ0_ACK      = ack_q[0];
  assign REQ1_ACK      = ack_q[1];
  assign RESP0_VALID   = (state_q == S_RESPOND) && !port_q;
  assign RESP1_VALID   = (state_q == S_RESPOND) &&  port_q;
  assign RESP_RDATA    = rdata_q;
  assign RESP_ERR      = err_q;
  assign ACTIVATE      = activate;
  assign MUST_CONTINUE = must_cont_q;
  assign BUS_ADDR      = bus_addr_q;
  assign BUS_SIZE      = bus_size_q;
  assign BUS_RW        = rw_q;
  assign BUS_DOUT      = bus_dout_q;

endmodule

// File: tb/tb_bus_cycle_scheduler.sv
// Scoreboard bench for bus_cycle_scheduler: requesters push expected responses and
// bus cycles, a negedge monitor pops and compares; a small bus-FSM model drives FSM_STATE.
module tb_bus_cycle_scheduler;
  import bus_cycle_scheduler_pkg::*;

  localparam int unsigned AW = 24;

  logic          CLK = 1'b0;
  logic          nRESET = 1'b0;
  logic          REQ0_VALID, REQ0_RW, REQ1_VALID, REQ1_RW;
  logic [AW-1:0] REQ0_ADDR, REQ1_ADDR;
  logic [1:0]    REQ0_SIZE, REQ1_SIZE;
  logic [31:0]   REQ0_WDATA, REQ1_WDATA;
  logic          REQ0_ACK, REQ1_ACK, RESP0_VALID, RESP1_VALID, RESP_ERR;
  logic [31:0]   RESP_RDATA;
  logic [3:0]    FSM_STATE;
  logic [15:0]   BUS_DIN;
  logic          ACTIVATE, MUST_CONTINUE, BUS_RW;
  logic [AW-1:0] BUS_ADDR;
  logic [1:0]    BUS_SIZE;
  logic [15:0]   BUS_DOUT;

  always #5 CLK = ~CLK;

  bus_cycle_scheduler #(.ADDR_W(AW)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_SIZE(REQ0_SIZE),
    .REQ0_RW(REQ0_RW), .REQ0_WDATA(REQ0_WDATA), .REQ0_ACK(REQ0_ACK),
    .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_SIZE(REQ1_SIZE),
    .REQ1_RW(REQ1_RW), .REQ1_WDATA(REQ1_WDATA), .REQ1_ACK(REQ1_ACK),
    .RESP0_VALID(RESP0_VALID), .RESP1_VALID(RESP1_VALID),
    .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR),
    .FSM_STATE(FSM_STATE), .BUS_DIN(BUS_DIN),
    .ACTIVATE(ACTIVATE), .MUST_CONTINUE(MUST_CONTINUE),
    .BUS_ADDR(BUS_ADDR), .BUS_SIZE(BUS_SIZE), .BUS_RW(BUS_RW), .BUS_DOUT(BUS_DOUT)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory seen by the bus: a fixed hash of the word address, or a forced pattern.
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_val = 16'h0;

  function automatic logic [15:0] din_of(input logic [AW-1:0] a);
    if (ovr_en) return ovr_val;
    return 16'(a[AW-1:1] * 23'h9E37) ^ 16'h5A3C;
  endfunction

  // Bus-cycle FSM model: waits in WAIT, runs one cycle per ACTIVATE and
  // chains a second cycle through CONTINUE while MUST_CONTINUE is high.
  logic [3:0] fs_q;
  int         dly;
  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      fs_q <= STATE_WAIT;
      dly  <= 0;
    end else begin
      case (fs_q)
        STATE_WAIT:          if (ACTIVATE) fs_q <= STATE_SETUP_BUS;
        STATE_SETUP_BUS:     fs_q <= STATE_ASSERT_STROBE;
        STATE_ASSERT_STROBE: begin fs_q <= STATE_WAIT_DSACK; dly <= int'($urandom_range(0, 2)); end
        STATE_WAIT_DSACK:    if (dly == 0) fs_q <= STATE_LATCH; else dly <= dly - 1;
        STATE_LATCH:         fs_q <= STATE_FINALIZE;
        STATE_FINALIZE:      fs_q <= MUST_CONTINUE ? STATE_CONTINUE : STATE_WAIT;
        STATE_CONTINUE:      fs_q <= STATE_SETUP_BUS;
        default:             fs_q <= STATE_WAIT;
      endcase
    end
  end
  assign FSM_STATE = fs_q;
  assign BUS_DIN   = din_of(BUS_ADDR);

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          rw;
    logic [31:0]   wdata;
    logic          err;
    logic [31:0]   rdata;
  } txn_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          rw;
    logic [15:0]   dout;
    logic          mc;
  } cyc_t;

  txn_t pend[2][$];
  cyc_t busq[$];
  int   ack_log[$];
  int   act_cnt = 0;
  bit   ptr_m = 1'b0;
  logic [1:0] pv = '0;

  function automatic txn_t mk_txn(input logic [AW-1:0] a, input logic [1:0] s,
                                  input logic rw, input logic [31:0] w);
    txn_t t;
    logic [15:0] d;
    t.addr = a; t.size = s; t.rw = rw; t.wdata = w;
    t.err = (s == 2'd0) || (s >= 2'd2 && a[0]);
    t.rdata = '0;
    d = din_of(a);
    if (!t.err && rw) begin
      if (s == SIZE_LONG)      t.rdata = {d, din_of(AW'(a + 2))};
      else if (s == SIZE_WORD) t.rdata = {16'h0, d};
      else                     t.rdata = {24'h0, (a[0] ? d[7:0] : d[15:8])};
    end
    return t;
  endfunction

  function automatic void push_cycles(input txn_t t);
    cyc_t c;
    if (t.err) return;
    c.rw = t.rw;
    c.addr = t.addr;
    c.size = (t.size == SIZE_BYTE) ? SIZE_BYTE : SIZE_WORD;
    c.mc = (t.size == SIZE_LONG);
    if (t.size == SIZE_LONG)      c.dout = t.wdata[31:16];
    else if (t.size == SIZE_WORD) c.dout = t.wdata[15:0];
    else                          c.dout = {t.wdata[7:0], t.wdata[7:0]};
    busq.push_back(c);
    if (t.size == SIZE_LONG) begin
      c.addr = AW'(t.addr + 2);
      c.dout = t.wdata[15:0];
      c.mc = 1'b0;
      busq.push_back(c);
    end
  endfunction

  function automatic logic [31:0] any_out();
    return 32'({REQ0_ACK, REQ1_ACK, RESP0_VALID, RESP1_VALID, RESP_ERR, ACTIVATE,
                MUST_CONTINUE, BUS_SIZE, BUS_RW}) | RESP_RDATA | 32'(BUS_ADDR) | 32'(BUS_DOUT);
  endfunction

  // Monitor
  int   mp, mw;
  txn_t mt;
  cyc_t mc;
  always @(negedge CLK) begin
    if (nRESET) begin
      if (REQ0_ACK || REQ1_ACK) begin
        chk("ack_onehot", 32'(REQ0_ACK & REQ1_ACK), 32'd0);
        mp = REQ1_ACK ? 1 : 0;
        if (pv[0] && pv[1]) mw = ptr_m ? 1 : 0;
        else if (pv[1])     mw = 1;
        else if (pv[0])     mw = 0;
        else                mw = -1;
        chk("arb_winner", mp, mw);
        ptr_m = ~ptr_m;
        ack_log.push_back(mp);
        chk("ack_has_request", 32'(pend[mp].size() > 0), 32'd1);
        if (pend[mp].size() > 0) push_cycles(pend[mp][0]);
      end
      if (ACTIVATE) act_cnt++;
      if (FSM_STATE == STATE_SETUP_BUS) begin
        chk("bus_cycle_expected", 32'(busq.size() > 0), 32'd1);
        if (busq.size() > 0) begin
          mc = busq.pop_front();
          chk("bus_addr", 32'(BUS_ADDR), 32'(mc.addr));
          chk("bus_size", 32'(BUS_SIZE), 32'(mc.size));
          chk("bus_rw", 32'(BUS_RW), 32'(mc.rw));
          chk("bus_dout", 32'(BUS_DOUT), 32'(mc.dout));
          chk("must_continue", 32'(MUST_CONTINUE), 32'(mc.mc));
        end
      end
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? RESP0_VALID : RESP1_VALID) begin
          chk("resp_has_request", 32'(pend[p].size() > 0), 32'd1);
          if (pend[p].size() > 0) begin
            mt = pend[p].pop_front();
            chk("resp_err", 32'(RESP_ERR), 32'(mt.err));
            if (mt.rw || mt.err) chk("resp_rdata", RESP_RDATA, mt.rdata);
          end
        end
      end
      chk("resp_onehot", 32'(RESP0_VALID & RESP1_VALID), 32'd0);
    end
    pv = {REQ1_VALID, REQ0_VALID};
  end

  function automatic logic ack_of(input int p);
    return (p == 0) ? REQ0_ACK : REQ1_ACK;
  endfunction

  function automatic logic resp_of(input int p);
    return (p == 0) ? RESP0_VALID : RESP1_VALID;
  endfunction

  task automatic set_valid(input int p, input logic v);
    if (p == 0) REQ0_VALID = v; else REQ1_VALID = v;
  endtask

  task automatic issue_req(input int p, input txn_t t, output int lat);
    pend[p].push_back(t);
    if (p == 0) begin
      REQ0_ADDR = t.addr; REQ0_SIZE = t.size; REQ0_RW = t.rw; REQ0_WDATA = t.wdata;
    end else begin
      REQ1_ADDR = t.addr; REQ1_SIZE = t.size; REQ1_RW = t.rw; REQ1_WDATA = t.wdata;
    end
    set_valid(p, 1'b1);
    lat = 0;
    while (lat < 100) begin
      @(posedge CLK); #1;
      lat++;
      if (ack_of(p)) break;
    end
    chk("ack_seen", 32'(ack_of(p)), 32'd1);
    set_valid(p, 1'b0);
  endtask

  task automatic wait_resp(input int p);
    int n = 0;
    while (!resp_of(p) && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("resp_seen", 32'(resp_of(p)), 32'd1);
  endtask

  task automatic do_req(input int p, input logic [AW-1:0] a, input logic [1:0] s,
                        input logic rw, input logic [31:0] w, output int lat);
    issue_req(p, mk_txn(a, s, rw, w), lat);
    wait_resp(p);
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    pend[0].delete(); pend[1].delete(); busq.delete();
    ptr_m = 1'b0; pv = '0;
    repeat (2) @(posedge CLK);
    #1 nRESET = 1'b1;
  endtask

  task automatic rand_port(input int p, input int n);
    int lat;
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
      if ($urandom_range(0, 7) == 0) a = 24'hFFFFFE | AW'($urandom_range(0, 1));
      else                           a = AW'($urandom_range(0, 4095));
      do_req(p, a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, lat);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, n;
    REQ0_VALID = 0; REQ0_ADDR = '0; REQ0_SIZE = '0; REQ0_RW = 0; REQ0_WDATA = '0;
    REQ1_VALID = 0; REQ1_ADDR = '0; REQ1_SIZE = '0; REQ1_RW = 0; REQ1_WDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs_zero", any_out(), 32'd0);
    nRESET = 1'b1;

    // Word read returning 0xBEEF
    ovr_en = 1'b1; ovr_val = 16'hBEEF;
    a0 = act_cnt;
    do_req(0, 24'h000100, SIZE_WORD, 1'b1, 32'h0, lat);
    chk("word_read_rdata", RESP_RDATA, 32'h0000BEEF);
    chk("word_ack_latency", lat, 1);
    chk("word_activates", act_cnt - a0, 1);
    ovr_en = 1'b0;

    // Long write split into 0x200/0x1234 and 0x202/0x5678
    a0 = act_cnt;
    do_req(1, 24'h000200, SIZE_LONG, 1'b0, 32'h12345678, lat);
    chk("long_write_activates", act_cnt - a0, 1);
    chk("long_write_mc_low", 32'(MUST_CONTINUE), 32'd0);

    // Both ports raised together from reset, each twice
    do_reset();
    ack_log.delete();
    fork
      begin do_req(0, 24'h000010, SIZE_WORD, 1'b1, 32'h0, lat);
            do_req(0, 24'h000012, SIZE_WORD, 1'b0, 32'hCAFE, lat); end
      begin do_req(1, 24'h000020, SIZE_BYTE, 1'b1, 32'h0, lat);
            do_req(1, 24'h000022, SIZE_LONG, 1'b1, 32'h0, lat); end
    join
    chk("rr_grant_count", ack_log.size(), 4);
    for (int i = 0; i < ack_log.size() && i < 4; i++) chk("rr_grant_order", ack_log[i], i % 2);

    // Misaligned long: error, no bus cycle
    a0 = act_cnt;
    do_req(0, 24'h000101, SIZE_LONG, 1'b1, 32'h0, lat);
    chk("misaligned_err", 32'(RESP_ERR), 32'd1);
    chk("misaligned_rdata", RESP_RDATA, 32'd0);
    chk("misaligned_no_activate", act_cnt - a0, 0);

    // Byte lanes
    ovr_en = 1'b1; ovr_val = 16'hAA55;
    do_req(0, 24'h000301, SIZE_BYTE, 1'b1, 32'h0, lat);
    chk("byte_odd_rdata", RESP_RDATA, 32'h00000055);
    do_req(0, 24'h000300, SIZE_BYTE, 1'b1, 32'h0, lat);
    chk("byte_even_rdata", RESP_RDATA, 32'h000000AA);
    ovr_en = 1'b0;

    // Long at the top word wraps to address 0
    do_req(1, 24'hFFFFFE, SIZE_LONG, 1'b1, 32'h0, lat);
    do_req(1, 24'hFFFFFE, SIZE_LONG, 1'b0, 32'hA1B2C3D4, lat);

    // Reset during WAIT_DSACK of a long cycle
    issue_req(0, mk_txn(24'h000500, SIZE_LONG, 1'b1, 32'h0), lat);
    n = 0;
    while (FSM_STATE != STATE_WAIT_DSACK && n < 50) begin @(posedge CLK); #1; n++; end
    chk("reached_wait_dsack", 32'(FSM_STATE == STATE_WAIT_DSACK), 32'd1);
    nRESET = 1'b0;
    #1;
    chk("midreset_outputs_zero", any_out(), 32'd0);
    do_reset();
    repeat (3) begin @(posedge CLK); #1; end
    do_req(1, 24'h000400, SIZE_WORD, 1'b1, 32'h0, lat);
    chk("after_reset_ack_latency", lat, 1);

    // Randomized traffic on both ports
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (5) begin @(posedge CLK); #1; end

    chk("pend0_drained", pend[0].size(), 0);
    chk("pend1_drained", pend[1].size(), 0);
    chk("busq_drained", busq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
